// File: rtl/wb_uart_pkg.sv
// Shared definitions for wb_uart: register map / bit position macros, FSM state type
// and the divisor clamp helper.
`ifndef WB_UART_DEFINES
`define WB_UART_DEFINES
`define UART_REG_DATA      2'd0
`define UART_REG_STATUS    2'd1
`define UART_REG_CTRL      2'd2
`define UART_REG_DIV       2'd3
`define UART_ST_RX_NEMPTY  0
`define UART_ST_RX_FULL    1
`define UART_ST_TX_EMPTY   2
`define UART_ST_TX_FULL    3
`define UART_ST_TX_BUSY    4
`define UART_ST_RX_OVR     5
`define UART_ST_FRM_ERR    6
`define UART_ST_TX_OVF     7
`define UART_CTRL_RX_IE    0
`define UART_CTRL_TX_IE    1
`define UART_DIV_MIN       16'd4
`endif

package wb_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Divisors below the minimum leave no room for a mid-bit sample point.
    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        return (value < `UART_DIV_MIN) ? `UART_DIV_MIN : value;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with combinational head read. A push on a full FIFO only lands when a
// pop happens in the same cycle; a pop on an empty FIFO is ignored and reads as zero.
module uart_fifo
    import wb_uart_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/wb_uart.sv
// Wishbone B3 classic slave UART: 8N1 transmit/receive through 8-entry FIFOs, runtime baud
// divisor latched per frame, sticky error flags and a level interrupt.
module wb_uart
    import wb_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 43
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        uart_rxd_i,
    output logic        uart_txd_o,
    output logic        uart_int_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Handshake: a request is cyc&stb while ack is low; ack answers one cycle later for
    // exactly one cycle, and all register side effects commit at the end of that ack cycle.
    logic        ack_q;
    logic [1:0]  reg_sel;
    logic        acc_wr;
    logic        acc_rd;
    logic [1:0]  ctrl_q;
    logic [15:0] div_q;
    logic [2:0]  sticky_q;
    logic [7:0]  status;
    logic [31:0] rd_data;

    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    tx_rdata;
    logic [CW-1:0] tx_count;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_rdata;
    logic [CW-1:0] rx_count;
    logic          tx_ovf_set, rx_ovr_set, frm_set, status_clr;
    logic          unused_bits;

    assign reg_sel    = wb_adr_i[3:2];
    assign acc_wr     = ack_q & wb_we_i & wb_sel_i[0];
    assign acc_rd     = ack_q & ~wb_we_i;
    assign tx_push    = acc_wr & (reg_sel == `UART_REG_DATA);
    assign rx_pop     = acc_rd & (reg_sel == `UART_REG_DATA);
    assign status_clr = acc_rd & (reg_sel == `UART_REG_STATUS);
    assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
    assign rx_ovr_set = rx_push & rx_full & ~rx_pop;
    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = ack_q ? rd_data : 32'd0;
    assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:1],
                           tx_count, rx_count};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            ctrl_q   <= 2'b00;
            div_q    <= 16'(DIV_RESET);
            sticky_q <= 3'b000;
        end else begin
            ack_q <= wb_cyc_i & wb_stb_i & ~ack_q;
            if (acc_wr && reg_sel == `UART_REG_CTRL) ctrl_q <= wb_dat_i[1:0];
            if (acc_wr && reg_sel == `UART_REG_DIV)  div_q  <= clamp_div(wb_dat_i[15:0]);
            // An error arriving in the clearing cycle must survive the clear.
            sticky_q <= (status_clr ? 3'b000 : sticky_q) | {tx_ovf_set, frm_set, rx_ovr_set};
        end
    end

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .push(tx_push), .wdata(wb_dat_i[7:0]), .pop(tx_pop),
        .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    // ---------------------------------------------------------------- TX state machine
    uart_state_t tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_end;

    assign tx_end = (tx_cnt == tx_div - 16'd1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= 16'd0;
            tx_div   <= 16'(DIV_RESET);
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 16'd1;
        tx_div_n   = tx_div;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        case (tx_state)
            ST_IDLE: begin
                tx_cnt_n = 16'd0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_rdata;
                    tx_div_n   = div_q;
                    tx_state_n = ST_START;
                end
            end
            ST_START: begin
                if (tx_end) begin
                    tx_cnt_n   = 16'd0;
                    tx_bit_n   = 3'd0;
                    tx_state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_end) begin
                    tx_cnt_n   = 16'd0;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    tx_bit_n   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tx_end) begin
                    tx_cnt_n   = 16'd0;
                    tx_state_n = ST_IDLE;
                    // Chain straight into the next frame so there is no idle gap.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = tx_rdata;
                        tx_div_n   = div_q;
                        tx_state_n = ST_START;
                    end
                end
            end
            default: tx_state_n = ST_IDLE;
        endcase
    end

    assign uart_txd_o = (tx_state == ST_START) ? 1'b0 :
                        (tx_state == ST_DATA)  ? tx_shift[0] : 1'b1;

    // ---------------------------------------------------------------- RX path
    logic rx_s1, rx_s2, rx_prev;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rxd_i;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    uart_state_t rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_bit_end, rx_half_end;

    assign rx_bit_end  = (rx_cnt == rx_div - 16'd1);
    assign rx_half_end = (rx_cnt == (rx_div >> 1) - 16'd1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= 16'd0;
            rx_div   <= 16'(DIV_RESET);
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 16'd1;
        rx_div_n   = rx_div;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        frm_set    = 1'b0;
        case (rx_state)
            ST_IDLE: begin
                rx_cnt_n = 16'd0;
                if (rx_prev && !rx_s2) begin
                    rx_div_n   = div_q;
                    rx_state_n = ST_START;
                end
            end
            ST_START: begin
                if (rx_half_end) begin
                    rx_cnt_n   = 16'd0;
                    rx_bit_n   = 3'd0;
                    rx_state_n = rx_s2 ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_n   = 16'd0;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (rx_bit_end) begin
                    rx_cnt_n   = 16'd0;
                    rx_push    = rx_s2;
                    frm_set    = ~rx_s2;
                    rx_state_n = ST_IDLE;
                end
            end
            default: rx_state_n = ST_IDLE;
        endcase
    end

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .push(rx_push), .wdata(rx_shift), .pop(rx_pop),
        .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // ---------------------------------------------------------------- read mux / interrupt
    always_comb begin
        status                     = 8'd0;
        status[`UART_ST_RX_NEMPTY] = ~rx_empty;
        status[`UART_ST_RX_FULL]   = rx_full;
        status[`UART_ST_TX_EMPTY]  = tx_empty;
        status[`UART_ST_TX_FULL]   = tx_full;
        status[`UART_ST_TX_BUSY]   = (tx_state != ST_IDLE);
        status[`UART_ST_RX_OVR]    = sticky_q[0];
        status[`UART_ST_FRM_ERR]   = sticky_q[1];
        status[`UART_ST_TX_OVF]    = sticky_q[2];
    end

    always_comb begin
        rd_data = 32'd0;
        case (reg_sel)
            `UART_REG_DATA:   rd_data = {24'd0, rx_rdata};
            `UART_REG_STATUS: rd_data = {24'd0, status};
            `UART_REG_CTRL:   rd_data = {30'd0, ctrl_q};
            `UART_REG_DIV:    rd_data = {16'd0, div_q};
            default:          rd_data = 32'd0;
        endcase
    end

    assign uart_int_o = (ctrl_q[`UART_CTRL_RX_IE] & ~rx_empty) |
                        (ctrl_q[`UART_CTRL_TX_IE] & tx_empty & (tx_state == ST_IDLE));

endmodule

// File: tb/tb_wb_uart.sv
// Bench for wb_uart: register access, serial TX/RX framing, FIFO limits, sticky errors,
// loopback and reset during a frame, against a byte-queue reference model.
module tb_wb_uart;

    localparam int DEPTH = 8;
    localparam logic [1:0] R_DATA = 2'd0, R_STATUS = 2'd1, R_CTRL = 2'd2, R_DIV = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = 32'd0, dat_w = 32'd0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] dat_r;
    logic        ack, txd, irq, rxd;
    logic        rxd_drv = 1'b1;
    logic        loop_en = 1'b0;
    bit          mon_en = 1'b0;
    int          cur_div = 43;
    int          checks = 0;
    int          passes = 0;

    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];
    logic [2:0] sticky_exp = 3'b000;   // {tx_ovf, frm_err, rx_ovr}

    assign rxd = loop_en ? txd : rxd_drv;

    always #5 clk = ~clk;

    wb_uart #(.FIFO_DEPTH(DEPTH), .DIV_RESET(43)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel), .wb_dat_o(dat_r), .wb_ack_o(ack),
        .uart_rxd_i(rxd), .uart_txd_o(txd), .uart_int_o(irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wb_xfer(input logic w, input logic [1:0] r, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] q);
        int n;
        n = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = {28'd0, r, 2'b00}; dat_w = d; sel = s;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        if (!ack) check("wb_ack_timeout", {31'd0, ack}, 32'd1);
        q = dat_r;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] r, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, r, d, 4'hF, q);
    endtask

    task automatic wb_read(input logic [1:0] r, output logic [31:0] q);
        wb_xfer(1'b0, r, 32'd0, 4'hF, q);
    endtask

    // Model status while the transmitter is idle.
    function automatic logic [31:0] idle_status();
        logic [7:0] s;
        s = {sticky_exp, 1'b0, 1'b0, 1'b1, rx_exp_q.size() == DEPTH, rx_exp_q.size() != 0};
        return {24'd0, s};
    endfunction

    task automatic read_data_check(input string tag);
        logic [31:0] q;
        logic [31:0] exp;
        exp = (rx_exp_q.size() != 0) ? {24'd0, rx_exp_q.pop_front()} : 32'd0;
        wb_read(R_DATA, q);
        check(tag, q, exp);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd_drv = f[i];
            repeat (cur_div) @(negedge clk);
        end
        rxd_drv = 1'b1;
        repeat (2 * cur_div) @(negedge clk);
        if (!stop) sticky_exp[1] = 1'b1;
        else if (rx_exp_q.size() < DEPTH) rx_exp_q.push_back(b);
        else sticky_exp[0] = 1'b1;
    endtask

    task automatic wait_tx_idle();
        logic [31:0] st;
        int n;
        n = 0;
        do begin
            wb_read(R_STATUS, st);
            sticky_exp = 3'b000;
            n++;
        end while (st[4:2] != 3'b001 && n < 1000);
        if (st[4:2] != 3'b001) check("tx_idle_timeout", st, 32'h04);
    endtask

    // Serial decoder on txd: every decoded frame is checked against the TX queue.
    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && txd === 1'b0) begin
                repeat (cur_div / 2) @(negedge clk);
                check("mon_start", {31'd0, txd}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (cur_div) @(negedge clk);
                    b[i] = txd;
                end
                repeat (cur_div) @(negedge clk);
                check("mon_stop", {31'd0, txd}, 32'd1);
                if (tx_exp_q.size() == 0) check("mon_unexpected", {24'd0, b}, 32'hFFFF_FFFF);
                else check("mon_byte", {24'd0, b}, {24'd0, tx_exp_q.pop_front()});
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] q;
        logic [7:0]  b;
        logic [9:0]  frame;
        logic [7:0]  lb [5];

        // Reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_int", {31'd0, irq}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", dat_r, 32'd0);
        rst = 1'b0;
        wb_read(R_STATUS, q); check("rst_status", q, 32'h04);
        wb_read(R_DIV, q);    check("rst_div", q, 32'd43);
        wb_read(R_CTRL, q);   check("rst_ctrl", q, 32'd0);

        // Held strobe: one ack every two cycles
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8;
        @(negedge clk); check("ack_hold_0", {31'd0, ack}, 32'd1);
        @(negedge clk); check("ack_hold_1", {31'd0, ack}, 32'd0);
        @(negedge clk); check("ack_hold_2", {31'd0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0;

        // Divisor clamp, upper-half masking, byte-select gating, CTRL readback
        wb_write(R_DIV, 32'd2);           wb_read(R_DIV, q); check("div_clamp", q, 32'd4);
        wb_write(R_DIV, 32'hABCD_0009);   wb_read(R_DIV, q); check("div_low16", q, 32'd9);
        wb_xfer(1'b1, R_DIV, 32'd20, 4'hE, q);
        wb_read(R_DIV, q); check("div_sel0_off", q, 32'd9);
        wb_write(R_CTRL, 32'd3);          wb_read(R_CTRL, q); check("ctrl_rw", q, 32'd3);
        wb_write(R_CTRL, 32'd0);

        // RX single frame and interrupt
        wb_write(R_DIV, 32'd4); cur_div = 4;
        rx_frame(8'h3C, 1'b1);
        wb_read(R_STATUS, q); check("rx_status", q, idle_status());
        wb_write(R_CTRL, 32'd1);
        @(negedge clk); check("rx_int_on", {31'd0, irq}, 32'd1);
        read_data_check("rx_data");
        check("rx_int_during_ack", {31'd0, irq}, 32'd1);
        @(negedge clk); check("rx_int_off", {31'd0, irq}, 32'd0);
        read_data_check("rx_data_empty");
        wb_write(R_CTRL, 32'd0);

        // Overrun and framing error, sticky clear on read
        for (int i = 0; i < DEPTH + 1; i++) rx_frame(8'($urandom_range(0, 255)), 1'b1);
        rx_frame(8'($urandom_range(0, 255)), 1'b0);
        wb_read(R_STATUS, q); check("err_status_1", q, idle_status());
        sticky_exp = 3'b000;
        wb_read(R_STATUS, q); check("err_status_2", q, idle_status());
        for (int i = 0; i < DEPTH; i++) read_data_check("rx_drain");
        wb_read(R_STATUS, q); check("rx_drained_status", q, idle_status());

        // TX single frame with exact timing
        mon_en = 1'b1;
        b = 8'hA5;
        frame = {1'b1, b, 1'b0};
        tx_exp_q.push_back(b);
        wb_write(R_DATA, {24'd0, b});
        @(negedge clk); check("tx_lat_hi", {31'd0, txd}, 32'd1);
        @(negedge clk); check("tx_lat_lo", {31'd0, txd}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            repeat (k == 0 ? 1 : cur_div) @(negedge clk);
            check("tx_bit", {31'd0, txd}, {31'd0, frame[k]});
        end
        wait_tx_idle();
        wb_write(R_CTRL, 32'd2);
        @(negedge clk); check("tx_int_idle", {31'd0, irq}, 32'd1);
        wb_write(R_CTRL, 32'd0);

        // TX burst: one byte in flight plus a full FIFO, the next write overflows
        for (int i = 0; i < DEPTH + 2; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i < DEPTH + 1) tx_exp_q.push_back(b);
            else sticky_exp[2] = 1'b1;
            wb_write(R_DATA, {24'd0, b});
        end
        wb_read(R_STATUS, q);
        check("tx_burst_status", q, {24'd0, sticky_exp, 5'b11000});
        sticky_exp = 3'b000;
        wait_tx_idle();
        check("tx_drained", tx_exp_q.size(), 32'd0);

        // Loopback at a random divisor
        cur_div = $urandom_range(4, 8);
        wb_write(R_DIV, cur_div);
        loop_en = 1'b1;
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h55;
        lb[3] = 8'($urandom_range(0, 255)); lb[4] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 5; i++) begin
            tx_exp_q.push_back(lb[i]);
            rx_exp_q.push_back(lb[i]);
            wb_write(R_DATA, {24'd0, lb[i]});
        end
        wait_tx_idle();
        repeat (4 * cur_div) @(negedge clk);
        for (int i = 0; i < 5; i++) read_data_check("loop_data");
        wb_read(R_STATUS, q); check("loop_status", q, idle_status());
        check("loop_tx_drained", tx_exp_q.size(), 32'd0);
        loop_en = 1'b0;

        // Reset in the middle of a frame
        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) wb_write(R_DATA, 32'd0);
        repeat (3 * cur_div) @(negedge clk);
        check("rst_mid_pre", {31'd0, txd}, 32'd0);
        rst = 1'b1;
        @(negedge clk); check("rst_mid_txd", {31'd0, txd}, 32'd1);
        rst = 1'b0;
        sticky_exp = 3'b000;
        cur_div = 43;
        wb_read(R_STATUS, q); check("rst_mid_status", q, 32'h04);
        wb_read(R_DIV, q);    check("rst_mid_div", q, 32'd43);
        repeat (50) @(negedge clk);
        check("rst_mid_txd_idle", {31'd0, txd}, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
